// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// mux_scan : registered N-channel W-bit selector, manual or round-robin scan
// Rev 1.0
// ============================================================================
module mux_scan #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int SW  = $clog2(N),
  parameter int DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            hold,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  output logic            tick
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [SW:0]   C_NUM_CH  = N[SW:0];
  localparam logic [SW-1:0] C_LAST_CH = SW'(N - 1);
  localparam logic [CW-1:0] C_CNT_END = CW'(DIV - 1);

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  state_t          st_q, st_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SW-1:0]   out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic            tick_q, tick_d;

  logic            w_sel_ok;
  logic [SW-1:0]   w_start_ch;
  logic [SW-1:0]   w_next_ch;

  // Returns zero for an index with no channel behind it.
  function automatic logic [W-1:0] pick(input logic [SW-1:0] idx,
                                        input logic [N*W-1:0] bus);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = bus[k*W +: W];
    end
    return r;
  endfunction

  assign w_sel_ok   = ({1'b0, sel} < C_NUM_CH);
  assign w_start_ch = w_sel_ok ? sel : '0;
  assign w_next_ch  = (ch_q == C_LAST_CH) ? '0 : ch_q + SW'(1);

  always_comb begin
    st_d        = st_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    tick_d      = 1'b0;

    if (!hold) begin
      if (!mode) begin
        // Manual rule applies both while staying in MANUAL and on exit from AUTO.
        st_d        = MANUAL;
        cnt_d       = '0;
        out_ch_d    = sel;
        out_data_d  = pick(sel, in_data);
        out_valid_d = w_sel_ok;
      end else if (st_q == MANUAL) begin
        st_d        = AUTO;
        cnt_d       = '0;
        ch_d        = w_start_ch;
        out_ch_d    = w_start_ch;
        out_data_d  = pick(w_start_ch, in_data);
        out_valid_d = 1'b1;
      end else if (cnt_q == C_CNT_END) begin
        cnt_d       = '0;
        ch_d        = w_next_ch;
        out_ch_d    = w_next_ch;
        out_data_d  = pick(w_next_ch, in_data);
        out_valid_d = 1'b1;
        tick_d      = 1'b1;
      end else begin
        cnt_d       = cnt_q + CW'(1);
        out_ch_d    = ch_q;
        out_data_d  = pick(ch_q, in_data);
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= MANUAL;
      ch_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      tick_q      <= tick_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign tick      = tick_q;

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit selector with two operating modes. In manual mode it forwards the channel picked by `sel`. In auto-scan mode an internal prescaler steps through the channels round-robin and pulses `tick` on each step. It sits between the input switch/data sources and the LED/seven-segment display path, replacing the fixed 4:1 single-bit selector.

## Interface
- `W`, default 8: data width per channel (≥1).
- `N`, default 4: number of channels (≥2).
- `SW`, default $clog2(N): select/channel index width. Derived; do not override.
- `DIV`, default 16: prescaler period in clock cycles per auto-scan step (≥1).

- `clk`  in  1: single clock. Everything is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  N*W: channel k occupies bits [k*W+W-1 : k*W].
- `sel`  in  SW: manual channel index. Also the start channel for auto mode.
- `mode`  in  1: 0 = manual, 1 = auto-scan.
- `hold`  in  1: freezes all internal and output registers.
- `out_data`  out  W: registered data of the current channel.
- `out_ch`  out  SW: registered index of the channel shown on `out_data`.
- `out_valid`  out  1: high when `out_data` comes from a legal channel.
- `tick`  out  1: one-cycle pulse, coincident with each auto-scan channel advance.

## Operation
- FSM states: MANUAL and AUTO. State register is `st`. Internal registers are channel `ch` (SW bits) and prescaler `cnt` (width $clog2(DIV)+1).
- Reset (`rst`=1 at an edge) sets:
  - `st`=MANUAL, `ch`=0, `cnt`=0;
  - `out_data`=0, `out_ch`=0, `out_valid`=0, `tick`=0.
  - Reset overrides `hold` and `mode`.
- `hold`=1 (not in reset): every register keeps its value, `tick` is forced to 0, and `mode` is ignored. Mode changes take effect on the first edge with `hold`=0.
- MANUAL, `mode`=0:
  - `out_ch`<=`sel`, `out_data`<=channel `sel`, `out_valid`<=1.
  - If `sel`≥N (possible when N is not a power of 2): `out_data`<=0, `out_valid`<=0, `out_ch`<=`sel`.
  - `cnt` is held at 0.
- MANUAL→AUTO (edge with `mode`=1, `st`=MANUAL):
  - `st`<=AUTO, `cnt`<=0.
  - `ch`<=`sel` if `sel`<N, else 0.
  - Outputs load from that start channel on the same edge. `tick`=0.
- AUTO, `mode`=1:
  - If `cnt`==DIV-1: `cnt`<=0, `ch`<=(`ch`==N-1 ? 0 : `ch`+1), outputs load from the new channel, `tick`<=1.
  - Otherwise: `cnt`<=`cnt`+1, outputs reload from the current `ch` (data tracks input), `tick`<=0.
  - `out_valid` is always 1 in AUTO.
- AUTO→MANUAL (edge with `mode`=0): `st`<=MANUAL, `cnt`<=0, `tick`<=0, and outputs follow the MANUAL rule with the current `sel`. `ch` keeps its value, unused until the next AUTO entry.
- Wrap-around: from channel N-1 the next channel is 0. `cnt` never exceeds DIV-1.
- With DIV=1 the channel advances on every AUTO edge after entry, and `tick` stays high continuously.

## Timing
- Latency is 1 cycle: `in_data`/`sel` sampled at edge k appear on `out_data`/`out_ch` after edge k. There is no combinational input-to-output path.
- In AUTO, each channel is shown for exactly DIV cycles, except the entry channel, which is shown for DIV cycles counted from the entry edge.
- `tick` goes high after the same edge on which `out_ch` changes to the new channel. It lasts one cycle, unless DIV=1.
- Simultaneous events:
  - `rst` beats `hold`, and `hold` beats `mode`.
  - A mode change on the cycle where `cnt`==DIV-1 takes the mode transition. There is no advance and no `tick`.
- Asserting `rst` mid-scan returns the block to MANUAL with all outputs at 0 on the next edge. `out_valid` stays 0 until the first non-reset edge.

## Test plan
1. **Manual select.** Setup: W=8, N=4, `in_data`=32'hDDCCBBAA, `mode`=0. Stimulus: sweep `sel` 0..3. Required: one cycle later `out_data`=AA, BB, CC, DD; `out_ch` equals `sel`; `out_valid`=1.
2. **Reset.** Stimulus: assert `rst` with `mode`=1 and `hold`=1. Required: after the next edge all outputs are 0 and `st`=MANUAL. After release with `mode`=0 and `sel`=2, `out_data`=CC one cycle later.
3. **Auto scan.** Setup: DIV=4, `sel`=2. Stimulus: set `mode`=1. Required:
   - `out_ch` sequence 2,2,2,2,3,3,3,3,0,… (wraps 3→0);
   - `tick` high exactly on the first cycle of channels 3, 0, 1;
   - changing `in_data` mid-dwell shows on `out_data` one cycle later.
4. **Hold.** Stimulus: assert `hold` for 5 cycles in AUTO with `cnt`=2. Required: outputs frozen and `tick`=0 throughout. After release, the channel advances after exactly 2 more edges (1 increment, then the advance).
5. **Illegal select and DIV=1.** Setup: N=3, `sel`=3 in MANUAL. Required: `out_valid`=0 and `out_data`=0. Then with DIV=1 and `mode`=1: `out_ch` reads 0,1,2,0,… one step per cycle, and `tick` stays 1 after entry.
6. **Mode exit on advance cycle.** Stimulus: drop `mode` on the cycle `cnt`==DIV-1. Required: no `tick`, `out_ch`=`sel` after the edge. Re-entry to AUTO restarts `cnt` from 0.
